// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Synchronizes and debounces a raw button level; emits clean
//               level, one-cycle rise/fall pulses and an accepted-press count.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic       iD,
    output logic       oLevel,
    output logic       oRise,
    output logic       oFall,
    output logic       oBusy,
    output logic [7:0] oCount
);

    typedef enum logic [1:0] {
        c_IDLE_LOW  = 2'd0,
        c_WAIT_HIGH = 2'd1,
        c_IDLE_HIGH = 2'd2,
        c_WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO = '0;

    logic                 r_s1;
    logic                 r_s2;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_level;
    logic                 w_level_nxt;
    logic                 r_rise;
    logic                 w_rise_nxt;
    logic                 r_fall;
    logic                 w_fall_nxt;
    logic [7:0]           r_count;
    logic [7:0]           w_count_nxt;

    // Two-flop synchronizer; only r_s2 feeds the qualifier.
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= iD;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            r_state <= c_IDLE_LOW;
            r_cnt   <= c_CNT_ZERO;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Pulses default low so each one lasts exactly the acceptance cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_count_nxt = r_count;
        case (r_state)
            c_IDLE_LOW: begin
                if (r_s2) begin
                    w_state_nxt = c_WAIT_HIGH;
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            end
            c_WAIT_HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = c_IDLE_LOW;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_IDLE_HIGH;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_count_nxt = r_count + 8'd1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            c_IDLE_HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = c_WAIT_LOW;
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            end
            c_WAIT_LOW: begin
                if (r_s2) begin
                    w_state_nxt = c_IDLE_HIGH;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_IDLE_LOW;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE_LOW;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    assign oLevel = r_level;
    assign oRise  = r_rise;
    assign oFall  = r_fall;
    assign oBusy  = (r_state == c_WAIT_HIGH) || (r_state == c_WAIT_LOW);
    assign oCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Directed and random stimulus for button_debouncer, compared
//               each cycle against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int STABLE = 4;

    logic       clk;
    logic       rst;
    logic       d;
    logic       level;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    button_debouncer #(
        .STABLE_CYCLES (STABLE),
        .CNT_WIDTH     (16)
    ) u_dut (
        .iclk   (clk),
        .irst   (rst),
        .iD     (d),
        .oLevel (level),
        .oRise  (rise),
        .oFall  (fall),
        .oBusy  (busy),
        .oCount (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the qualifier sees the input two edges late; a level change is
    // accepted once the late sample has differed from the level for STABLE+1
    // consecutive edges.
    bit         m_hist[$];
    bit         m_valid = 1'b0;
    logic       m_level;
    logic       m_rise;
    logic       m_fall;
    logic [7:0] m_count;
    int         m_run;

    always @(posedge clk) begin : p_model
        bit v;
        if (rst) begin
            m_hist  = '{1'b0, 1'b0};
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_count = 8'd0;
            m_run   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            v = m_hist.pop_front();
            m_hist.push_back(d);
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (v != m_level) begin
                m_run = m_run + 1;
                if (m_run == STABLE + 1) begin
                    m_level = v;
                    if (v) begin
                        m_rise  = 1'b1;
                        m_count = m_count + 8'd1;
                    end else begin
                        m_fall = 1'b1;
                    end
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        if (m_valid) begin
            chk("mdl_level", {7'd0, level}, {7'd0, m_level});
            chk("mdl_rise",  {7'd0, rise},  {7'd0, m_rise});
            chk("mdl_fall",  {7'd0, fall},  {7'd0, m_fall});
            chk("mdl_busy",  {7'd0, busy},  {7'd0, (m_run != 0)});
            chk("mdl_count", count, m_count);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {3'd0, level, rise, fall, busy, 1'b0}, 8'd0);
        chk({name, "_cnt"}, count, 8'd0);
    endtask

    initial begin : p_stim
        int n_rise;
        bit seen_busy;
        bit seen_level;
        bit found;
        d   = 1'b0;
        rst = 1'b1;

        // Reset held with the button pressed: outputs stay zero.
        d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all_zero("rst_hold");
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rst_rel_level", {7'd0, level}, (i >= 7) ? 8'd1 : 8'd0);
            chk("rst_rel_rise",  {7'd0, rise},  (i == 7) ? 8'd1 : 8'd0);
            chk("rst_rel_count", count,         (i >= 7) ? 8'd1 : 8'd0);
        end

        // Clean release then clean press.
        d = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rel_fall",  {7'd0, fall},  (i == 7) ? 8'd1 : 8'd0);
            chk("rel_level", {7'd0, level}, (i < 7) ? 8'd1 : 8'd0);
        end
        repeat (4) tick();
        d = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("press_rise",  {7'd0, rise},  (i == 7) ? 8'd1 : 8'd0);
            chk("press_level", {7'd0, level}, (i >= 7) ? 8'd1 : 8'd0);
        end
        chk("press_count", count, 8'd2);
        d = 1'b0;
        repeat (10) tick();

        // Bounce 1,0,1,0 then hold high: one accepted rise.
        n_rise = 0;
        for (int i = 0; i < 4; i++) begin
            d = (i % 2 == 0);
            tick();
            n_rise += int'(rise);
        end
        d = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("bounce_rise_t", {7'd0, rise}, (i == 7) ? 8'd1 : 8'd0);
            n_rise += int'(rise);
        end
        chk("bounce_nrise", n_rise[7:0], 8'd1);
        chk("bounce_count", count, 8'd3);
        d = 1'b0;
        repeat (10) tick();

        // Three-cycle glitch: qualifier busies but level never moves.
        seen_busy  = 1'b0;
        seen_level = 1'b0;
        n_rise     = 0;
        d = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) d = 1'b0;
            tick();
            seen_busy  |= busy;
            seen_level |= level;
            n_rise     += int'(rise);
        end
        chk("glitch_busy_seen", {7'd0, seen_busy},  8'd1);
        chk("glitch_level",     {7'd0, seen_level}, 8'd0);
        chk("glitch_nrise",     n_rise[7:0],        8'd0);
        chk("glitch_busy_end",  {7'd0, busy},       8'd0);

        // Reset mid-qualification discards the candidate.
        d     = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            found = busy;
        end
        chk("midrst_busy_found", {7'd0, found}, 8'd1);
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("midrst_after");
        rst = 1'b0;
        d   = 1'b0;
        n_rise = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_rise += int'(rise);
        end
        chk("midrst_nrise", n_rise[7:0], 8'd0);

        // Counter wrap over 257 presses (count is zero after the reset above).
        for (int p = 1; p <= 257; p++) begin
            d = 1'b1;
            repeat (8) tick();
            if (p == 255) chk("wrap_255", count, 8'd255);
            if (p == 256) chk("wrap_256", count, 8'd0);
            if (p == 257) chk("wrap_257", count, 8'd1);
            d = 1'b0;
            repeat (8) tick();
        end

        // Random segments with occasional resets, model-checked every cycle.
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                d   = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) tick();
                rst = 1'b0;
            end
            d = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, STABLE + 4)) tick();
        end
        d = 1'b0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : p_timeout
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/button_debouncer.md
# button_debouncer

Upstream conditioning stage for the D flip-flop and other clocked lab blocks: takes a raw, asynchronous, bouncing push-button/switch input and produces a clean, synchronized level. It also produces single-cycle rise/fall pulses and a count of accepted presses. Its `oLevel` output is the intended driver for a flop's `iD`, and `oRise` is intended as a one-shot enable.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: number of consecutive synchronized samples at the new value required to accept a transition; legal range 1 to 2^`CNT_WIDTH`.
- `CNT_WIDTH`, default 16: width of the internal stability counter.

Ports:
- `iclk`, input, 1: single clock; all state updates on its posedge.
- `irst`, input, 1: reset, synchronous and active-high.
- `iD`, input, 1: raw asynchronous button/switch level.
- `oLevel`, output, 1: debounced level.
- `oRise`, output, 1: one-cycle pulse on an accepted 0→1 transition.
- `oFall`, output, 1: one-cycle pulse on an accepted 1→0 transition.
- `oBusy`, output, 1: high while a candidate transition is being qualified.
- `oCount`, output, 8: number of accepted rising transitions, modulo 256.

## Operation
- **Synchronizer:** two flops, `s1 <= iD` and `s2 <= s1`. Only `s2` is used downstream.
- **States:** `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`. The stability counter is `cnt`.
- **`IDLE_LOW`:**
  - `s2 = 1`: go to `WAIT_HIGH`, `cnt <= 0`.
  - Otherwise: stay.
- **`WAIT_HIGH`:**
  - `s2 = 0`: return to `IDLE_LOW`, `cnt <= 0`, no pulse.
  - `s2 = 1` and `cnt = STABLE_CYCLES-1`: go to `IDLE_HIGH`, `oLevel <= 1`, `oRise <= 1`, `oCount <= oCount+1`.
  - Otherwise: `cnt <= cnt+1`.
- **`IDLE_HIGH` / `WAIT_LOW`:** mirror image of the above, with target level 0. Acceptance sets `oLevel <= 0` and `oFall <= 1`. `oCount` is unchanged.
- **Pulse width:** `oRise` and `oFall` are registered and cleared on every cycle in which they are not being set, so each is exactly one cycle wide. They are never high together.
- **`oBusy`:** a decode of the state register, high in `WAIT_HIGH` and `WAIT_LOW`.
- **`oCount` wrap:** wraps 255 → 0 with no flag.
- **Reset:** dominates all other activity.
  - On a reset cycle: `s1 = s2 = 0`, state `IDLE_LOW`, `cnt = 0`.
  - All outputs are 0 during and after reset, including `oCount = 0`.
  - Reset asserted mid-qualification discards the candidate and emits no pulse.

## Timing
- **Rising latency:** let `iD` be stably 1 from before posedge k. Then:
  - posedge k: `s1 = 1`.
  - posedge k+1: `s2 = 1`.
  - posedge k+2: enter `WAIT_HIGH`.
  - posedge k+STABLE_CYCLES+2: `oLevel = 1`, `oRise = 1`.
  - posedge k+STABLE_CYCLES+3: `oRise = 0`.
- **Falling latency:** same, with `oFall`.
- **Filtering:** a pulse on `iD` shorter than STABLE_CYCLES+1 cycles is filtered and produces no output change; `oBusy` may still pulse.
- **Level held through reset:** if `iD = 1` throughout reset, and r is the first posedge with `irst = 0`, then `oLevel`/`oRise` assert at posedge r+STABLE_CYCLES+2.
- **`STABLE_CYCLES = 1`:** acceptance occurs on the first `WAIT_*` cycle, giving latency k+3.
- **No combinational paths:** none from `iD` or `irst` to any output.

## Test plan
All scenarios use `STABLE_CYCLES = 4`.

- **Reset:** hold `irst = 1` for 3 cycles with `iD = 1` → all outputs 0 during reset. After release, `oLevel` and `oRise` go to 1 at posedge r+6, and `oCount = 1`.
- **Clean press/release:** raise `iD` before posedge 10 → `oRise` high only for the cycle after posedge 16, `oLevel = 1`. Drop `iD` before posedge 30 → `oFall` high only after posedge 36, `oLevel = 0`.
- **Bounce:** toggle `iD` 1,0,1,0 on consecutive cycles, then hold 1 → exactly one `oRise` and `oCount` +1. The acceptance edge is 6 posedges after the final 0→1 sample.
- **Glitch:** a 3-cycle high pulse on `iD` → `oLevel` stays 0, no `oRise`, and `oBusy` goes high then returns to 0.
- **Counter wrap:** apply 257 clean presses → `oCount` reads 255 after press 255, 0 after press 256, and 1 after press 257.
- **Reset mid-wait:** assert `irst` one cycle after `oBusy` rises during a press → no `oRise`. The outputs are all 0 on the cycle after the reset edge.
